hazard_lock_unit: RTL
=====================

# hazard_lock_unit

Pipeline interlock controller on the decode→ALU boundary. It monitors the instruction held in the decode/ALU pipeline register (opcode, destination), the source registers of the instruction in decode, the data-cache handshake and branch resolution. From these it drives the register advance enable (`locker`), the front-end hold and the bubble marker (`CSLToALUMEM`) that the decode/ALU register captures. It handles load-use stalls, data-cache miss freezes and taken-branch flushes.

## Interface
Parameters:
- `LOAD_OPCODE`, 7'b0000011: opcode treated as a load.
- `FLUSH_CYCLES`, 2: number of bubbles injected after a taken branch (1..3).
- `MAX_WAIT`, 15: cache-wait cycles before `memTimeout` is raised (1..255).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state clears immediately on assertion.
- `opCodeEx`  in  7  opcode of the instruction in the EX stage (decode/ALU register output).
- `writeEnableEx`  in  1  EX instruction writes the register file.
- `writeBackAddrEx`  in  5  EX destination register.
- `dataS1AddrDec`, `dataS2AddrDec`  in  5 each  source registers of the decode-stage instruction.
- `useS1Dec`, `useS2Dec`  in  1 each  the decode instruction actually reads that source.
- `dataCacheReq`  in  1  MEM stage is issuing a data-cache access this cycle.
- `dataCacheReady`  in  1  data cache completes the access this cycle.
- `branchTaken`  in  1  taken branch/jump resolved in EX this cycle.
- `locker`  out  1  1 = decode/ALU and later pipeline registers advance; 0 = hold.
- `frontHold`  out  1  1 = PC and IF/ID hold.
- `CSLToALUMEM`  out  1  1 = the value captured into decode/ALU this edge is a bubble (downstream kills write enables).
- `memTimeout`  out  1  sticky: a cache wait exceeded `MAX_WAIT`.
- `stallCount`  out  16  saturating count of cycles with `frontHold`=1.

## Operation
- States: RUN, MEM_WAIT, FLUSH.
- Hazard terms (combinational):
  - `missNow` = `dataCacheReq` & !`dataCacheReady`.
  - `loadUse` = (`opCodeEx`==`LOAD_OPCODE`) & `writeEnableEx` & (`writeBackAddrEx`!=0) & ((`useS1Dec` & S1 match) | (`useS2Dec` & S2 match)).
- Priority when several terms are true in the same cycle: `missNow` > `branchTaken` > `loadUse`.
- RUN:
  - `missNow`: `locker`=0, `frontHold`=1, `CSLToALUMEM`=0; next state MEM_WAIT; wait counter loads 1.
  - else `branchTaken`: `locker`=1, `frontHold`=0, `CSLToALUMEM`=1; next state FLUSH with flush counter = `FLUSH_CYCLES`-1. If `FLUSH_CYCLES`=1, stay in RUN.
  - else `loadUse`: `locker`=1, `frontHold`=1, `CSLToALUMEM`=1. This inserts exactly one bubble; the hazard clears next cycle because EX then holds the bubble.
  - else: `locker`=1, `frontHold`=0, `CSLToALUMEM`=0.
- MEM_WAIT:
  - `dataCacheReady`=0: `locker`=0, `frontHold`=1; wait counter increments, saturating at 255. `memTimeout` sets when the counter reaches `MAX_WAIT`. The block stays in MEM_WAIT indefinitely.
  - `dataCacheReady`=1: outputs as in RUN for this cycle (`locker`=1); next state RUN.
- FLUSH:
  - `locker`=1, `frontHold`=0, `CSLToALUMEM`=1; flush counter decrements; return to RUN after the last bubble.
  - A `missNow` during FLUSH takes priority: go to MEM_WAIT with the remaining flush count preserved, then resume FLUSH.
  - `branchTaken` and `loadUse` during FLUSH are ignored, because EX holds bubbles.
- `stallCount` increments on every clock with `frontHold`=1 and saturates at 16'hFFFF.
- `memTimeout` clears only on reset.

## Timing
- All outputs are combinational from state plus current inputs; zero-cycle response. The decode/ALU register samples them on the same edge.
- State, wait counter, flush counter, `stallCount` and `memTimeout` are flops with asynchronous clear on `reset`=0.
- Output values while `reset`=0: state RUN, `locker`=1, `frontHold`=0, `CSLToALUMEM`=1 (pipeline fills with bubbles), `memTimeout`=0, `stallCount`=0.
- Reset asserted mid-MEM_WAIT or mid-FLUSH abandons the sequence; the first cycle after release is RUN.
- Load-use costs exactly 1 cycle. A cache miss costs N cycles where N = cycles until `dataCacheReady`. A taken branch costs `FLUSH_CYCLES` bubbles.

## Structure
- `LOAD_OPCODE`, the state encodings and the `OpcodeSize`/`RegAddrSize` widths belong in `define.v`, shared with the decoder and the pipeline registers.
- Single module. The saturating `stallCount` may be a small sub-module `sat_counter16`; nothing else is split out.

## Test plan
- Load x5 in EX, decode reads x5 via S2 (`useS2Dec`=1) -> one cycle with `frontHold`=1, `locker`=1, `CSLToALUMEM`=1; next cycle all deasserted; `stallCount`=1. Same scenario with rd=x0 -> no stall.
- `dataCacheReq`=1, `dataCacheReady`=0 for 4 cycles, then ready -> `locker`=0 and `frontHold`=1 for 4 cycles, `locker`=1 in the ready cycle, `memTimeout`=0.
- Cache wait of 20 cycles with `MAX_WAIT`=15 -> `memTimeout` rises on wait cycle 15, remains 1 after ready, clears only on `reset`.
- `branchTaken` pulse with `FLUSH_CYCLES`=2 -> `CSLToALUMEM`=1 for exactly 2 cycles, `locker`=1, `frontHold`=0 throughout. A `loadUse` condition asserted in the second cycle is ignored.
- Same cycle `missNow`, `branchTaken` and `loadUse` -> MEM_WAIT behaviour; after ready, 1 remaining flush bubble.
- `reset` pulled low in the 2nd cycle of a cache wait -> immediately `locker`=1, `CSLToALUMEM`=1, `stallCount`=0; after release the block is in RUN.

Source files
------------

// File: rtl/hazard_lock_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_lock_unit_pkg
// Shared definitions for the decode->ALU interlock: instruction field widths,
// the load opcode, interlock FSM state encoding, the bundled pipeline control
// word and a small source/destination match helper.
// -----------------------------------------------------------------------------
package hazard_lock_unit_pkg;

  localparam int OPCODE_SIZE   = 7;
  localparam int REG_ADDR_SIZE = 5;

  localparam logic [OPCODE_SIZE-1:0] LOAD_OPCODE_DEFAULT = 7'b0000011;

  // Cache-wait counter width; the counter saturates at its all-ones value.
  localparam int WAIT_CNT_W = 8;
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_SAT = 8'hFF;

  // Flush counter only ever holds FLUSH_CYCLES-1, i.e. at most 2.
  localparam int FLUSH_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } hl_state_e;

  // Control word driven towards the pipeline registers.
  typedef struct packed {
    logic locker;      // 1 = decode/ALU and later registers advance
    logic front_hold;  // 1 = PC and IF/ID hold
    logic bubble;      // 1 = value captured into decode/ALU is a bubble
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_PASS   = '{locker: 1'b1, front_hold: 1'b0, bubble: 1'b0};
  localparam pipe_ctrl_t CTRL_FREEZE = '{locker: 1'b0, front_hold: 1'b1, bubble: 1'b0};
  localparam pipe_ctrl_t CTRL_BUBBLE = '{locker: 1'b1, front_hold: 1'b0, bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_STALL  = '{locker: 1'b1, front_hold: 1'b1, bubble: 1'b1};

  // True when the decode instruction really reads src and src equals dst.
  function automatic logic reg_match(
    input logic                     use_src,
    input logic [REG_ADDR_SIZE-1:0] src,
    input logic [REG_ADDR_SIZE-1:0] dst
  );
    return use_src & (src == dst);
  endfunction

endpackage

// File: rtl/hazard_lock_unit_sat_counter16.sv
// -----------------------------------------------------------------------------
// sat_counter16
// 16-bit counter that increments on every clock with inc=1 and sticks at
// 16'hFFFF. Cleared asynchronously while reset is low.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low clear
//   inc    in   count this cycle
//   count  out  current count
// -----------------------------------------------------------------------------
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  // Saturating count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 16'h0000;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_lock_unit.sv
// -----------------------------------------------------------------------------
// hazard_lock_unit
// Interlock controller on the decode->ALU boundary. Detects load-use hazards,
// data-cache misses and taken branches, and drives the advance enable, the
// front-end hold and the bubble marker captured into the decode/ALU register.
// Ports:
//   clk, reset                      clock / async active-low reset
//   opCodeEx, writeEnableEx,
//   writeBackAddrEx                 instruction currently in EX
//   dataS1AddrDec, dataS2AddrDec,
//   useS1Dec, useS2Dec              sources of the decode instruction
//   dataCacheReq, dataCacheReady    data-cache handshake of the MEM stage
//   branchTaken                     taken branch resolved in EX
//   locker                          1 = pipeline registers advance
//   frontHold                       1 = PC and IF/ID hold
//   CSLToALUMEM                     1 = decode/ALU captures a bubble
//   memTimeout                      sticky cache-wait timeout flag
//   stallCount                      saturating count of frontHold cycles
// -----------------------------------------------------------------------------
module hazard_lock_unit
  import hazard_lock_unit_pkg::*;
#(
  parameter logic [OPCODE_SIZE-1:0] LOAD_OPCODE  = LOAD_OPCODE_DEFAULT,
  parameter int                     FLUSH_CYCLES = 2,
  parameter int                     MAX_WAIT     = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OPCODE_SIZE-1:0]   opCodeEx,
  input  logic                     writeEnableEx,
  input  logic [REG_ADDR_SIZE-1:0] writeBackAddrEx,
  input  logic [REG_ADDR_SIZE-1:0] dataS1AddrDec,
  input  logic [REG_ADDR_SIZE-1:0] dataS2AddrDec,
  input  logic                     useS1Dec,
  input  logic                     useS2Dec,
  input  logic                     dataCacheReq,
  input  logic                     dataCacheReady,
  input  logic                     branchTaken,
  output logic                     locker,
  output logic                     frontHold,
  output logic                     CSLToALUMEM,
  output logic                     memTimeout,
  output logic [15:0]              stallCount
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT   = WAIT_CNT_W'(MAX_WAIT);

  hl_state_e              state_r;
  hl_state_e              state_next_s;
  logic [WAIT_CNT_W-1:0]  wait_cnt_r;
  logic [WAIT_CNT_W-1:0]  wait_cnt_next_s;
  logic [WAIT_CNT_W-1:0]  wait_cnt_inc_s;
  logic [FLUSH_CNT_W-1:0] flush_cnt_r;
  logic [FLUSH_CNT_W-1:0] flush_cnt_next_s;
  logic                   mem_timeout_r;
  logic                   waiting_s;
  logic                   timeout_set_s;
  logic                   miss_now_s;
  logic                   load_use_s;
  pipe_ctrl_t             ctrl_s;

  // Decision of a RUN cycle with no cache miss, reused by the MEM_WAIT ready cycle.
  pipe_ctrl_t             run_ctrl_s;
  hl_state_e              run_state_s;
  logic [FLUSH_CNT_W-1:0] run_flush_s;

  assign miss_now_s = dataCacheReq & ~dataCacheReady;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use_s = (opCodeEx == LOAD_OPCODE) & writeEnableEx &
                      (writeBackAddrEx != 5'd0) &
                      (reg_match(useS1Dec, dataS1AddrDec, writeBackAddrEx) |
                       reg_match(useS2Dec, dataS2AddrDec, writeBackAddrEx));

  assign wait_cnt_inc_s = (wait_cnt_r == WAIT_CNT_SAT) ? wait_cnt_r
                                                       : wait_cnt_r + 8'd1;

  // Branch / load-use resolution for a cycle that is not frozen by a miss.
  always_comb begin
    run_ctrl_s  = CTRL_PASS;
    run_state_s = ST_RUN;
    run_flush_s = {FLUSH_CNT_W{1'b0}};
    if (branchTaken) begin
      run_ctrl_s = CTRL_BUBBLE;
      // The first bubble is inserted this cycle; FLUSH supplies the rest.
      if (FLUSH_CYCLES > 1) begin
        run_state_s = ST_FLUSH;
        run_flush_s = FLUSH_RELOAD;
      end else begin
        run_state_s = ST_RUN;
        run_flush_s = {FLUSH_CNT_W{1'b0}};
      end
    end else if (load_use_s) begin
      // One bubble; EX holds that bubble next cycle so the hazard clears.
      run_ctrl_s = CTRL_STALL;
    end else begin
      run_ctrl_s = CTRL_PASS;
    end
  end

  // Next-state, counter and output decode of the interlock FSM.
  always_comb begin
    state_next_s     = state_r;
    wait_cnt_next_s  = wait_cnt_r;
    flush_cnt_next_s = flush_cnt_r;
    ctrl_s           = CTRL_PASS;
    waiting_s        = 1'b0;
    if (!reset) begin
      // Pipeline fills with bubbles while held in reset.
      state_next_s     = ST_RUN;
      wait_cnt_next_s  = {WAIT_CNT_W{1'b0}};
      flush_cnt_next_s = {FLUSH_CNT_W{1'b0}};
      ctrl_s           = CTRL_BUBBLE;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (miss_now_s) begin
            ctrl_s          = CTRL_FREEZE;
            state_next_s    = ST_MEM_WAIT;
            wait_cnt_next_s = 8'd1;
            waiting_s       = 1'b1;
          end else begin
            ctrl_s           = run_ctrl_s;
            state_next_s     = run_state_s;
            flush_cnt_next_s = run_flush_s;
          end
        end
        ST_MEM_WAIT: begin
          if (!dataCacheReady) begin
            ctrl_s          = CTRL_FREEZE;
            wait_cnt_next_s = wait_cnt_inc_s;
            waiting_s       = 1'b1;
          end else if (flush_cnt_r != 2'd0) begin
            // Miss interrupted a flush: resume the remaining bubbles.
            ctrl_s       = CTRL_PASS;
            state_next_s = ST_FLUSH;
          end else begin
            ctrl_s           = run_ctrl_s;
            state_next_s     = run_state_s;
            flush_cnt_next_s = run_flush_s;
          end
        end
        ST_FLUSH: begin
          if (miss_now_s) begin
            // Flush count is kept so the sequence resumes after the miss.
            ctrl_s          = CTRL_FREEZE;
            state_next_s    = ST_MEM_WAIT;
            wait_cnt_next_s = 8'd1;
            waiting_s       = 1'b1;
          end else begin
            ctrl_s           = CTRL_BUBBLE;
            flush_cnt_next_s = flush_cnt_r - 2'd1;
            state_next_s     = (flush_cnt_r == 2'd1) ? ST_RUN : ST_FLUSH;
          end
        end
        default: begin
          ctrl_s           = CTRL_BUBBLE;
          state_next_s     = ST_RUN;
          wait_cnt_next_s  = {WAIT_CNT_W{1'b0}};
          flush_cnt_next_s = {FLUSH_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Timeout fires on the edge at which the wait counter reaches the limit.
  assign timeout_set_s = waiting_s & (wait_cnt_next_s >= WAIT_LIMIT);

  // State, counters and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= {WAIT_CNT_W{1'b0}};
      flush_cnt_r   <= {FLUSH_CNT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      wait_cnt_r    <= wait_cnt_next_s;
      flush_cnt_r   <= flush_cnt_next_s;
      mem_timeout_r <= mem_timeout_r | timeout_set_s;
    end
  end

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl_s.front_hold),
    .count (stallCount)
  );

  assign locker      = ctrl_s.locker;
  assign frontHold   = ctrl_s.front_hold;
  assign CSLToALUMEM = ctrl_s.bubble;
  assign memTimeout  = mem_timeout_r;

endmodule
